// File: rtl/tx_code_group_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tx_code_group_encoder
// Purpose  : PCS transmit code-group encoder. Turns ordered-set requests
//            (/I/, /S/, /D/, /T/, /R/) into registered 10-bit 8B/10B code
//            groups, one per GTX_CLK, and tracks running disparity and
//            even/odd slot alignment.
// Options  : `define ENCODER_KIND_CHECK_EN to enable the tx_kind_err
//            request-legality check. Without it tx_kind_err is tied low.
// Revision : 1.0  initial release
// ============================================================================
module tx_code_group_encoder (
    input  logic       GTX_CLK,
    input  logic       mr_main_reset,
    input  logic [7:0] tx_o_set,
    input  logic [2:0] tx_o_set_kind,
    output logic [9:0] tx_code_group,
    output logic       tx_even,
    output logic       tx_disparity,
    output logic       tx_oset_indicate,
    output logic       tx_kind_err
);

    // Request encodings
    localparam logic [2:0] c_kind_i = 3'd0;
    localparam logic [2:0] c_kind_s = 3'd1;
    localparam logic [2:0] c_kind_d = 3'd2;
    localparam logic [2:0] c_kind_t = 3'd3;
    localparam logic [2:0] c_kind_r = 3'd4;

    // Special groups {abcdei,fghj}, RD- / RD+ variants
    localparam logic [9:0] c_k28_5_n = 10'b001111_1010;
    localparam logic [9:0] c_k28_5_p = 10'b110000_0101;
    localparam logic [9:0] c_k27_7_n = 10'b110110_1000;
    localparam logic [9:0] c_k27_7_p = 10'b001001_0111;
    localparam logic [9:0] c_k29_7_n = 10'b101110_1000;
    localparam logic [9:0] c_k29_7_p = 10'b010001_0111;
    localparam logic [9:0] c_k23_7_n = 10'b111010_1000;
    localparam logic [9:0] c_k23_7_p = 10'b000101_0111;

    // Octets of the second idle group: D5.6 (/I1/) and D16.2 (/I2/)
    localparam logic [7:0] c_d5_6  = 8'hC5;
    localparam logic [7:0] c_d16_2 = 8'h50;

    // FSM state names describe the group currently on the output
    typedef enum logic [1:0] {
        XMIT   = 2'd0,
        IDLE_K = 2'd1,
        IDLE_D = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [9:0]  r_code_group;
    logic        r_even;
    logic        r_rd;
    logic        r_indicate;
    logic [9:0]  w_next_cg;
    logic        w_next_rd;
    logic        w_next_ind;
    logic        w_idle_req;
    logic        w_slot_even;
    logic [10:0] w_idle_grp;
    logic [10:0] w_data_grp;

    // 8B/10B data encoder. Returns {rd_after, abcdei, fghj}.
    function automatic logic [10:0] enc_data(input logic [7:0] d, input logic rd_in);
        logic [4:0] x;
        logic [2:0] y;
        logic [5:0] six_n;
        logic [3:0] four_n;
        logic [5:0] six;
        logic [3:0] four;
        logic       comp6;
        logic       comp4;
        logic       rd_mid;
        logic       rd_out;
        logic       alt7;
        x      = d[4:0];
        y      = d[7:5];
        six_n  = 6'b000000;
        four_n = 4'b0000;
        // RD- column of the 5b/6b table
        case (x)
            5'd0:  six_n = 6'b100111;
            5'd1:  six_n = 6'b011101;
            5'd2:  six_n = 6'b101101;
            5'd3:  six_n = 6'b110001;
            5'd4:  six_n = 6'b110101;
            5'd5:  six_n = 6'b101001;
            5'd6:  six_n = 6'b011001;
            5'd7:  six_n = 6'b111000;
            5'd8:  six_n = 6'b111001;
            5'd9:  six_n = 6'b100101;
            5'd10: six_n = 6'b010101;
            5'd11: six_n = 6'b110100;
            5'd12: six_n = 6'b001101;
            5'd13: six_n = 6'b101100;
            5'd14: six_n = 6'b011100;
            5'd15: six_n = 6'b010111;
            5'd16: six_n = 6'b011011;
            5'd17: six_n = 6'b100011;
            5'd18: six_n = 6'b010011;
            5'd19: six_n = 6'b110010;
            5'd20: six_n = 6'b001011;
            5'd21: six_n = 6'b101010;
            5'd22: six_n = 6'b011010;
            5'd23: six_n = 6'b111010;
            5'd24: six_n = 6'b110011;
            5'd25: six_n = 6'b100110;
            5'd26: six_n = 6'b010110;
            5'd27: six_n = 6'b110110;
            5'd28: six_n = 6'b001110;
            5'd29: six_n = 6'b101110;
            5'd30: six_n = 6'b011110;
            5'd31: six_n = 6'b101011;
            default: six_n = 6'b000000;
        endcase
        // Unbalanced sub-blocks (and the balanced D.7) invert in RD+
        comp6  = ($countones(six_n) != 3) || (x == 5'd7);
        six    = (rd_in && comp6) ? ~six_n : six_n;
        rd_mid = ($countones(six_n) != 3) ? ~rd_in : rd_in;
        // A7 avoids a run of five across the sub-block boundary
        alt7   = (!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                 ( rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14));
        case (y)
            3'd0: four_n = 4'b1011;
            3'd1: four_n = 4'b1001;
            3'd2: four_n = 4'b0101;
            3'd3: four_n = 4'b1100;
            3'd4: four_n = 4'b1101;
            3'd5: four_n = 4'b1010;
            3'd6: four_n = 4'b0110;
            3'd7: four_n = alt7 ? 4'b0111 : 4'b1110;
            default: four_n = 4'b0000;
        endcase
        comp4  = (y == 3'd0) || (y == 3'd3) || (y == 3'd4) || (y == 3'd7);
        four   = (rd_mid && comp4) ? ~four_n : four_n;
        rd_out = ($countones(four_n) != 2) ? ~rd_mid : rd_mid;
        return {rd_out, six, four};
    endfunction

    // Idle and data groups encoded from the current running disparity
    assign w_idle_grp = enc_data(r_rd ? c_d16_2 : c_d5_6, r_rd);
    assign w_data_grp = enc_data(tx_o_set, r_rd);

    assign w_idle_req  = (tx_o_set_kind == c_kind_i) || (tx_o_set_kind > c_kind_r);
    assign w_slot_even = ~r_even;

    // Next-state selection and next output group
    always_comb begin
        w_next_state = XMIT;
        w_next_cg    = 10'h000;
        w_next_rd    = r_rd;
        w_next_ind   = 1'b1;

        if (r_state == IDLE_K) begin
            w_next_state = IDLE_D;
        end else if (w_idle_req && w_slot_even) begin
            w_next_state = IDLE_K;
        end else begin
            w_next_state = XMIT;
        end

        case (w_next_state)
            IDLE_K: begin
                w_next_cg  = r_rd ? c_k28_5_p : c_k28_5_n;
                w_next_rd  = ~r_rd;
                w_next_ind = 1'b0;
            end
            IDLE_D: begin
                {w_next_rd, w_next_cg} = w_idle_grp;
            end
            default: begin
                case (tx_o_set_kind)
                    c_kind_s: w_next_cg = r_rd ? c_k27_7_p : c_k27_7_n;
                    c_kind_d: {w_next_rd, w_next_cg} = w_data_grp;
                    c_kind_t: w_next_cg = r_rd ? c_k29_7_p : c_k29_7_n;
                    c_kind_r: w_next_cg = r_rd ? c_k23_7_p : c_k23_7_n;
                    default:  {w_next_rd, w_next_cg} = w_idle_grp;
                endcase
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            r_state      <= XMIT;
            r_code_group <= 10'h000;
            r_even       <= 1'b0;
            r_rd         <= 1'b0;
            r_indicate   <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_code_group <= w_next_cg;
            r_even       <= ~r_even;
            r_rd         <= w_next_rd;
            r_indicate   <= w_next_ind;
        end
    end

`ifdef ENCODER_KIND_CHECK_EN
    logic r_kind_err;
    logic w_kind_err;

    // Flag illegal kinds, misaligned /S/ and requests lost to the forced idle
    always_comb begin
        w_kind_err = (tx_o_set_kind > c_kind_r) ||
                     ((r_state == IDLE_K) && (tx_o_set_kind != c_kind_i)) ||
                     ((r_state != IDLE_K) && (tx_o_set_kind == c_kind_s) && !w_slot_even);
    end

    // Error flag registered alongside its group
    always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            r_kind_err <= 1'b0;
        end else begin
            r_kind_err <= w_kind_err;
        end
    end

    assign tx_kind_err = r_kind_err;
`else
    assign tx_kind_err = 1'b0;
`endif

    assign tx_code_group    = r_code_group;
    assign tx_even          = r_even;
    assign tx_disparity     = r_rd;
    assign tx_oset_indicate = r_indicate;

endmodule
`default_nettype wire

// File: tb/tb_tx_code_group_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_code_group_encoder
// Purpose  : Self-checking bench for tx_code_group_encoder: directed vector
//            table, reset sequences and an exhaustive /D/ sweep against an
//            independent two-column 8B/10B table.
// Options  : honours ENCODER_KIND_CHECK_EN for tx_kind_err expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_tx_code_group_encoder;

`ifdef ENCODER_KIND_CHECK_EN
    localparam logic c_kchk = 1'b1;
`else
    localparam logic c_kchk = 1'b0;
`endif

    localparam logic [2:0] c_i = 3'd0;
    localparam logic [2:0] c_s = 3'd1;
    localparam logic [2:0] c_d = 3'd2;
    localparam logic [2:0] c_t = 3'd3;
    localparam logic [2:0] c_r = 3'd4;

    logic       GTX_CLK = 1'b0;
    logic       mr_main_reset;
    logic [7:0] tx_o_set;
    logic [2:0] tx_o_set_kind;
    logic [9:0] tx_code_group;
    logic       tx_even;
    logic       tx_disparity;
    logic       tx_oset_indicate;
    logic       tx_kind_err;

    int n_vec = 0;
    int n_err = 0;

    tx_code_group_encoder dut (
        .GTX_CLK          (GTX_CLK),
        .mr_main_reset    (mr_main_reset),
        .tx_o_set         (tx_o_set),
        .tx_o_set_kind    (tx_o_set_kind),
        .tx_code_group    (tx_code_group),
        .tx_even          (tx_even),
        .tx_disparity     (tx_disparity),
        .tx_oset_indicate (tx_oset_indicate),
        .tx_kind_err      (tx_kind_err)
    );

    always #5 GTX_CLK = ~GTX_CLK;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
        logic [9:0] cg;
        logic       even;
        logic       rd;
        logic       ind;
        logic       err;
    } vec_t;

    vec_t vt [0:25];

    // Reference 8B/10B tables, RD- and RD+ columns written out separately
    logic [5:0] t6n [0:31] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    logic [5:0] t6p [0:31] = '{
        6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
        6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
        6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
        6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
    logic [3:0] t4n [0:7] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    logic [3:0] t4p [0:7] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};

    logic m_rd;
    logic m_even;
    logic m_last;
    int   m_run;

    function automatic logic [10:0] model_enc(input logic [7:0] d, input logic rd);
        logic [5:0] s;
        logic [3:0] f;
        logic       rdm;
        int         x;
        int         y;
        x   = int'(d[4:0]);
        y   = int'(d[7:5]);
        s   = rd ? t6p[x] : t6n[x];
        rdm = ($countones(s) == 3) ? rd : ~rd;
        if (y == 7 && ((!rdm && (x == 17 || x == 18 || x == 20)) ||
                       ( rdm && (x == 11 || x == 13 || x == 14))))
            f = rdm ? 4'b1000 : 4'b0111;
        else
            f = rdm ? t4p[y] : t4n[y];
        return {(($countones({s, f}) == 5) ? rd : ~rd), s, f};
    endfunction

    function automatic logic [13:0] dut_out();
        return {tx_kind_err, tx_oset_indicate, tx_disparity, tx_even, tx_code_group};
    endfunction

    task automatic chk(input string nm, input logic [13:0] got, input logic [13:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got {err,ind,rd,even,cg}=%h required %h", nm, got, exp);
        end
    endtask

    task automatic apply(input logic [2:0] k, input logic [7:0] d);
        tx_o_set_kind = k;
        tx_o_set      = d;
        @(posedge GTX_CLK);
        #1;
    endtask

    task automatic setv(input int i, input logic [2:0] k, input logic [7:0] d, input logic [9:0] cg,
                        input logic ev, input logic rd, input logic ind, input logic err);
        vt[i] = '{k, d, cg, ev, rd, ind, err};
    endtask

    // One /D/ group checked against the reference table and stream properties
    task automatic d_step(input logic [7:0] d);
        logic [10:0] e;
        logic        run_ok;
        logic        ones_ok;
        int          c;
        apply(c_d, d);
        e      = model_enc(d, m_rd);
        m_even = ~m_even;
        chk($sformatf("dexh_%02h_rd%0d", d, m_rd), dut_out(), {1'b0, 1'b1, e[10], m_even, e[9:0]});
        m_rd   = e[10];
        c       = $countones(tx_code_group);
        ones_ok = (c >= 4) && (c <= 6);
        run_ok  = 1'b1;
        for (int i = 9; i >= 0; i--) begin
            if (m_run > 0 && tx_code_group[i] == m_last) m_run++;
            else m_run = 1;
            m_last = tx_code_group[i];
            if (m_run > 5) run_ok = 1'b0;
        end
        chk($sformatf("dprop_%02h", d), {12'h000, ones_ok, run_ok}, 14'h0003);
    endtask

    initial begin
        //   idx kind data   cg      even rd ind err
        setv(0,  c_i, 8'h00, 10'h0FA, 1, 1, 0, 0);
        setv(1,  c_i, 8'h00, 10'h245, 0, 0, 1, 0);
        setv(2,  c_i, 8'h00, 10'h0FA, 1, 1, 0, 0);
        setv(3,  c_i, 8'h00, 10'h245, 0, 0, 1, 0);
        setv(4,  c_d, 8'h00, 10'h274, 1, 0, 1, 0);
        setv(5,  c_d, 8'h00, 10'h274, 0, 0, 1, 0);
        setv(6,  c_s, 8'h00, 10'h368, 1, 0, 1, 0);
        setv(7,  c_t, 8'h00, 10'h2E8, 0, 0, 1, 0);
        setv(8,  c_r, 8'h00, 10'h3A8, 1, 0, 1, 0);
        setv(9,  c_i, 8'h00, 10'h296, 0, 0, 1, 0);
        setv(10, c_i, 8'h00, 10'h0FA, 1, 1, 0, 0);
        setv(11, c_s, 8'h00, 10'h245, 0, 0, 1, c_kchk);
        setv(12, c_d, 8'h03, 10'h31B, 1, 1, 1, 0);
        setv(13, c_s, 8'h00, 10'h097, 0, 1, 1, c_kchk);
        setv(14, c_t, 8'h00, 10'h117, 1, 1, 1, 0);
        setv(15, c_r, 8'h00, 10'h057, 0, 1, 1, 0);
        setv(16, c_i, 8'h00, 10'h305, 1, 0, 0, 0);
        setv(17, c_d, 8'hFF, 10'h296, 0, 0, 1, c_kchk);
        setv(18, 3'd5, 8'h00, 10'h0FA, 1, 1, 0, c_kchk);
        setv(19, c_i, 8'h00, 10'h245, 0, 0, 1, 0);
        setv(20, c_d, 8'h00, 10'h274, 1, 0, 1, 0);
        setv(21, 3'd6, 8'h00, 10'h296, 0, 0, 1, c_kchk);
        setv(22, c_d, 8'hF1, 10'h237, 1, 1, 1, 0);
        setv(23, c_d, 8'hEB, 10'h348, 0, 0, 1, 0);
        setv(24, c_d, 8'hE7, 10'h38E, 1, 1, 1, 0);
        setv(25, c_d, 8'hE7, 10'h071, 0, 0, 1, 0);

        // Reset held from time zero
        mr_main_reset = 1'b0;
        tx_o_set_kind = c_i;
        tx_o_set      = 8'h00;
        @(posedge GTX_CLK);
        @(posedge GTX_CLK);
        #1;
        chk("rst_hold", dut_out(), 14'h0000);
        mr_main_reset = 1'b1;

        // Directed vectors from reset release
        for (int i = 0; i <= 25; i++) begin
            apply(vt[i].kind, vt[i].data);
            chk($sformatf("vec%0d", i), dut_out(),
                {vt[i].err, vt[i].ind, vt[i].rd, vt[i].even, vt[i].cg});
        end

        // Reset pulsed between edges mid-packet
        apply(c_d, 8'h00);
        chk("pre_rst", dut_out(), {1'b0, 1'b1, 1'b0, 1'b1, 10'h274});
        #3;
        mr_main_reset = 1'b0;
        #1;
        chk("rst_async", dut_out(), 14'h0000);
        @(posedge GTX_CLK);
        #1;
        chk("rst_held", dut_out(), 14'h0000);
        #3;
        mr_main_reset = 1'b1;
        apply(c_d, 8'h00);
        chk("rst_first", dut_out(), {1'b0, 1'b1, 1'b0, 1'b1, 10'h274});
        apply(c_i, 8'h00);
        chk("rst_odd_idle", dut_out(), {1'b0, 1'b1, 1'b0, 1'b0, 10'h296});
        apply(c_i, 8'h00);
        chk("rst_k28_5", dut_out(), {1'b0, 1'b0, 1'b1, 1'b1, 10'h0FA});
        apply(c_i, 8'h00);
        chk("rst_i2", dut_out(), {1'b0, 1'b1, 1'b0, 1'b0, 10'h245});

        // Exhaustive /D/ sweep, every octet from RD- then from RD+
        m_rd   = 1'b0;
        m_even = 1'b0;
        m_run  = 0;
        m_last = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int b = 0; b < 256; b++) begin
                if (m_rd != p[0]) d_step(8'h03);
                d_step(b[7:0]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
